// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : sample_tick_gen
// Brief    : Sample-rate tick and staggered per-voice slot strobe generator
//            with a shadowed, boundary-synchronised period divider.
//            Optional fractional divider: define SAMPLE_TICK_GEN_FRAC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sample_tick_gen #(
    parameter int CNT_W        = 10,
    parameter int DIV_DEFAULT  = 500,
    parameter int N_SLOT       = 3,
    parameter int SLOT_SPACING = 8,
    parameter int FRAC_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              restart_i,
    input  logic [CNT_W-1:0]  div_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    input  logic              div_we_i,
    output logic              tick_o,
    output logic [N_SLOT-1:0] slot_o,
    output logic [CNT_W-1:0]  period_o
);

    localparam logic [CNT_W-1:0] c_DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] c_DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_div_act;
    logic [CNT_W-1:0]  r_div_shd;
    logic              r_tick;
    logic [N_SLOT-1:0] r_slot;

    logic [CNT_W-1:0]  w_div_clamped;
    logic [CNT_W-1:0]  w_div_nxt;
    logic              w_wrap_hit;
    logic [N_SLOT-1:0] w_slot_hit;

    assign w_div_clamped = (div_i < c_DIV_MIN) ? c_DIV_MIN : div_i;
    // A write landing in the same cycle as a boundary bypasses the shadow.
    assign w_div_nxt     = div_we_i ? w_div_clamped : r_div_shd;

`ifdef SAMPLE_TICK_GEN_FRAC_EN
    logic [FRAC_W-1:0] r_frac_shd;
    logic [FRAC_W-1:0] r_acc;
    logic              r_ext;
    logic [FRAC_W-1:0] w_frac_nxt;
    logic [FRAC_W:0]   w_acc_sum;

    assign w_frac_nxt = div_we_i ? div_frac_i : r_frac_shd;
    assign w_acc_sum  = {1'b0, r_acc} + {1'b0, w_frac_nxt};
    // r_ext marks a period stretched by one cycle after an accumulator carry.
    assign w_wrap_hit = r_ext ? (r_cnt == r_div_act)
                              : (r_cnt == r_div_act - c_ONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frac_shd <= '0;
            r_acc      <= '0;
            r_ext      <= 1'b0;
        end else begin
            if (div_we_i) begin
                r_frac_shd <= div_frac_i;
            end
            if (restart_i) begin
                r_acc <= '0;
                r_ext <= 1'b0;
            end else if (en_i && w_wrap_hit) begin
                r_acc <= w_acc_sum[FRAC_W-1:0];
                r_ext <= w_acc_sum[FRAC_W];
            end
        end
    end
`else
    logic w_unused_frac;

    assign w_unused_frac = ^div_frac_i;
    assign w_wrap_hit    = (r_cnt == r_div_act - c_ONE);
`endif

    generate
        for (genvar k = 0; k < N_SLOT; k++) begin : g_slot
            localparam int c_SLOT_CNT = (k + 1) * SLOT_SPACING - 1;
            assign w_slot_hit[k] = (32'(r_cnt) == c_SLOT_CNT);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_div_act <= c_DIV_RST;
            r_div_shd <= c_DIV_RST;
            r_tick    <= 1'b0;
            r_slot    <= '0;
        end else begin
            r_tick <= 1'b0;
            r_slot <= '0;
            if (div_we_i) begin
                r_div_shd <= w_div_clamped;
            end
            if (restart_i) begin
                r_cnt     <= '0;
                r_div_act <= w_div_nxt;
            end else if (en_i) begin
                if (w_wrap_hit) begin
                    r_cnt     <= '0;
                    r_tick    <= 1'b1;
                    r_div_act <= w_div_nxt;
                end else begin
                    r_cnt  <= r_cnt + c_ONE;
                    // Suppressed on the wrap cycle so slots never collide with the tick.
                    r_slot <= w_slot_hit;
                end
            end
        end
    end

    assign tick_o   = r_tick;
    assign slot_o   = r_slot;
    assign period_o = r_div_act;

endmodule
`default_nettype wire

// File: tb/tb_sample_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_tick_gen
// Brief    : Directed self-checking bench for sample_tick_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_tick_gen;

    localparam int CNT_W  = 10;
    localparam int FRAC_W = 8;
    localparam int N_SLOT = 3;

    logic              clk_i;
    logic              rst_ni;
    logic              en_i;
    logic              restart_i;
    logic [CNT_W-1:0]  div_i;
    logic [FRAC_W-1:0] div_frac_i;
    logic              div_we_i;
    logic              tick_o;
    logic [N_SLOT-1:0] slot_o;
    logic [CNT_W-1:0]  period_o;

    int n_checks;
    int n_fail;
    int p_len;
    int p_pulses;
    int p_bad;
    int p_first[N_SLOT];
    int strobes;
    int sum;

    sample_tick_gen #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (500),
        .N_SLOT      (N_SLOT),
        .SLOT_SPACING(8),
        .FRAC_W      (FRAC_W)
    ) u_dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .restart_i (restart_i),
        .div_i     (div_i),
        .div_frac_i(div_frac_i),
        .div_we_i  (div_we_i),
        .tick_o    (tick_o),
        .slot_o    (slot_o),
        .period_o  (period_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_div(input int d, input int f);
        div_i      = CNT_W'(d);
        div_frac_i = FRAC_W'(f);
        div_we_i   = 1'b1;
        step();
        div_we_i   = 1'b0;
    endtask

    // Steps until tick_o, recording the period length and where each slot fired.
    task automatic run_period(input int budget);
        p_len    = 0;
        p_pulses = 0;
        p_bad    = 0;
        for (int k = 0; k < N_SLOT; k++) p_first[k] = -1;
        forever begin
            step();
            p_len++;
            for (int k = 0; k < N_SLOT; k++) begin
                if (slot_o[k]) begin
                    p_pulses++;
                    if (p_first[k] < 0) p_first[k] = p_len;
                end
            end
            if (slot_o != '0 && (tick_o || !$onehot(slot_o))) p_bad++;
            if (tick_o) break;
            if (p_len >= budget) begin
                check_eq("tick_within_budget", int'(tick_o), 1);
                break;
            end
        end
    endtask

    task automatic check_slots(input string tag, input int s0, input int s1,
                               input int s2, input int pulses);
        check_eq({tag, "_slot0"}, p_first[0], s0);
        check_eq({tag, "_slot1"}, p_first[1], s1);
        check_eq({tag, "_slot2"}, p_first[2], s2);
        check_eq({tag, "_pulses"}, p_pulses, pulses);
        check_eq({tag, "_overlap"}, p_bad, 0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_ni     = 1'b0;
        en_i       = 1'b1;
        restart_i  = 1'b0;
        div_i      = '0;
        div_frac_i = '0;
        div_we_i   = 1'b0;

        step_n(3);
        check_eq("rst_tick", int'(tick_o), 0);
        check_eq("rst_slot", int'(slot_o), 0);
        check_eq("rst_period", int'(period_o), 500);
        rst_ni = 1'b1;

        // Default period from reset release.
        run_period(600);
        check_eq("p500_first", p_len, 500);
        check_slots("p500_first", 8, 16, 24, 3);
        check_eq("p500_period", int'(period_o), 500);
        run_period(600);
        check_eq("p500_second", p_len, 500);
        check_slots("p500_second", 8, 16, 24, 3);
        run_period(600);
        check_eq("p500_third", p_len, 500);

        // Mid-period write only takes effect at the next boundary.
        step_n(249);
        write_div(100, 0);
        check_eq("shadow_period_hold", int'(period_o), 500);
        run_period(600);
        check_eq("shadow_old_len", p_len, 250);
        check_eq("shadow_new_period", int'(period_o), 100);
        run_period(200);
        check_eq("p100_len", p_len, 100);
        check_slots("p100", 8, 16, 24, 3);
        run_period(200);
        check_eq("p100_len2", p_len, 100);

        // Clamp to 2, then a 12-cycle period with only the first slot.
        write_div(1, 0);
        run_period(200);
        check_eq("clamp_old_len", p_len, 99);
        check_eq("clamp_period", int'(period_o), 2);
        for (int i = 0; i < 3; i++) begin
            run_period(10);
            check_eq("p2_len", p_len, 2);
            check_eq("p2_pulses", p_pulses, 0);
        end
        write_div(12, 0);
        run_period(10);
        check_eq("p2_last_len", p_len, 1);
        check_eq("p12_period", int'(period_o), 12);
        run_period(20);
        check_eq("p12_len", p_len, 12);
        check_slots("p12", 8, -1, -1, 1);

        // Enable dropped for 37 cycles mid-period.
        write_div(100, 0);
        run_period(20);
        check_eq("p12_last_len", p_len, 11);
        step_n(40);
        en_i    = 1'b0;
        strobes = 0;
        for (int i = 0; i < 37; i++) begin
            step();
            if (tick_o || slot_o != '0) strobes++;
        end
        check_eq("disabled_strobes", strobes, 0);
        en_i = 1'b1;
        run_period(200);
        check_eq("en_resume_len", p_len, 60);

        // Restart with a same-cycle write: no tick, new period immediately.
        step_n(30);
        restart_i = 1'b1;
        write_div(40, 0);
        restart_i = 1'b0;
        check_eq("restart_no_tick", int'(tick_o), 0);
        check_eq("restart_period", int'(period_o), 40);
        run_period(100);
        check_eq("restart_len", p_len, 40);
        check_slots("p40", 8, 16, 24, 3);

        // Restart wins over en_i low.
        step_n(10);
        en_i      = 1'b0;
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        step_n(5);
        en_i = 1'b1;
        run_period(100);
        check_eq("restart_disabled_len", p_len, 40);

        // Write in the wrap cycle is loaded directly.
        step_n(39);
        write_div(60, 0);
        check_eq("wrap_write_tick", int'(tick_o), 1);
        check_eq("wrap_write_period", int'(period_o), 60);
        run_period(100);
        check_eq("wrap_write_len", p_len, 60);

        // Asynchronous reset in the middle of a slot strobe.
        step_n(8);
        check_eq("pre_rst_slot", int'(slot_o), 1);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_slot", int'(slot_o), 0);
        check_eq("mid_rst_tick", int'(tick_o), 0);
        check_eq("mid_rst_period", int'(period_o), 500);
        step_n(2);
        rst_ni = 1'b1;
        run_period(600);
        check_eq("post_rst_len", p_len, 500);
        run_period(600);
        check_eq("post_rst_len2", p_len, 500);

`ifdef SAMPLE_TICK_GEN_FRAC_EN
        restart_i = 1'b1;
        write_div(10, 128);
        restart_i = 1'b0;
        run_period(20);
        check_eq("frac_p1", p_len, 10);
        run_period(20);
        check_eq("frac_p2", p_len, 10);
        sum = p_len;
        run_period(20);
        check_eq("frac_p3", p_len, 11);
        sum += p_len;
        for (int i = 0; i < 254; i++) begin
            run_period(20);
            sum += p_len;
        end
        check_eq("frac_sum256", sum, 2688);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
